cpu_microsequencer: RTL and testbench

- Parametrised next-generation micro-program sequencer for the CPU control path.
- Holds the micro-program counter (uPC) and advances it once per M-cycle. The next uPC is selected by the branch field of the current microinstruction (next, jump, conditional, dispatch, call, return, fetch).
- Adds real condition evaluation against CPU flags, a micro-subroutine return stack of parametrised depth, stall support, and sticky stack-error flags.
- Sits between the microcode ROM/decoder (which supplies the branch fields and dispatch address) and the control-signal decode.

---
 rtl/cpu_microsequencer.sv | 134 +++++++++++++
 tb/tb_cpu_microsequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_microsequencer.sv
// Micro-program sequencer: holds the uPC, selects the next microinstruction
// address per M-cycle, and keeps a bounded micro-subroutine return stack.
module cpu_microsequencer #(
  parameter int UPC_W       = 6,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 0,
  parameter int FETCH_ADDR  = 0,
  localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_cycle,
  input  logic               stall,
  input  logic [2:0]         ubranch,
  input  logic [UPC_W-1:0]   utarget,
  input  logic [1:0]         ucond,
  input  logic               flag_z,
  input  logic               flag_c,
  input  logic [UPC_W-1:0]   dispatch_addr,
  output logic [UPC_W-1:0]   upc,
  output logic               cond_taken,
  output logic [DEPTH_W-1:0] stack_depth,
  output logic               err_overflow,
  output logic               err_underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [UPC_W-1:0]   RESET_UPC = UPC_W'(RESET_ADDR);
  localparam logic [UPC_W-1:0]   FETCH_UPC = UPC_W'(FETCH_ADDR);
  localparam logic [DEPTH_W-1:0] FULL      = DEPTH_W'(STACK_DEPTH);

  typedef enum logic [2:0] {
    BR_NEXT     = 3'd0,
    BR_JUMP     = 3'd1,
    BR_CJUMP    = 3'd2,
    BR_DISPATCH = 3'd3,
    BR_CALL     = 3'd4,
    BR_RETURN   = 3'd5,
    BR_CRETURN  = 3'd6,
    BR_FETCH    = 3'd7
  } branch_e;

  typedef enum logic [1:0] {
    CC_NZ = 2'd0,
    CC_Z  = 2'd1,
    CC_NC = 2'd2,
    CC_C  = 2'd3
  } cond_e;

  logic [UPC_W-1:0]   stack_mem [STACK_DEPTH];
  logic [UPC_W-1:0]   upc_inc, upc_next;
  logic [DEPTH_W-1:0] depth_next, depth_dec;
  logic [IDX_W-1:0]   push_idx, pop_idx;
  logic               adv, push, set_ovf, set_unf;

  assign adv       = m_cycle & ~stall;
  assign upc_inc   = upc + UPC_W'(1);
  assign depth_dec = stack_depth - DEPTH_W'(1);
  assign push_idx  = stack_depth[IDX_W-1:0];
  assign pop_idx   = depth_dec[IDX_W-1:0];

  always_comb begin
    unique case (cond_e'(ucond))
      CC_NZ:   cond_taken = ~flag_z;
      CC_Z:    cond_taken = flag_z;
      CC_NC:   cond_taken = ~flag_c;
      default: cond_taken = flag_c;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    upc_next   = upc;
    depth_next = stack_depth;
    push       = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (adv) begin
      case (branch_e'(ubranch))
        BR_NEXT:     upc_next = upc_inc;
        BR_JUMP:     upc_next = utarget;
        BR_CJUMP:    upc_next = cond_taken ? utarget : upc_inc;
        BR_DISPATCH: upc_next = dispatch_addr;
        BR_CALL: begin
          upc_next = utarget;
          if (stack_depth < FULL) begin
            push       = 1'b1;
            depth_next = stack_depth + DEPTH_W'(1);
          end else begin
            set_ovf = 1'b1;
          end
        end
        BR_RETURN, BR_CRETURN: begin
          if (ubranch == BR_RETURN || cond_taken) begin
            if (stack_depth != '0) begin
              upc_next   = stack_mem[pop_idx];
              depth_next = depth_dec;
            end else begin
              upc_next = FETCH_UPC;
              set_unf  = 1'b1;
            end
          end else begin
            upc_next = upc_inc;
          end
        end
        default:     upc_next = FETCH_UPC;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upc           <= RESET_UPC;
      stack_depth   <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      upc           <= upc_next;
      stack_depth   <= depth_next;
      err_overflow  <= err_overflow | set_ovf;
      err_underflow <= err_underflow | set_unf;
    end
  end

  // NOTE: the stack array has no reset; its entries are only read below the
  // valid depth, which reset clears, so storage can map to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) stack_mem[push_idx] <= upc_inc;
  end

endmodule

// File: tb/tb_cpu_microsequencer.sv
// Self-checking bench for cpu_microsequencer: queue-based reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_cpu_microsequencer;

  localparam int UPC_W = 6;
  localparam int DEPTH = 4;
  localparam int MODV  = 1 << UPC_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             m_cycle, stall, flag_z, flag_c;
  logic [2:0]       ubranch;
  logic [1:0]       ucond;
  logic [UPC_W-1:0] utarget, dispatch_addr, upc;
  logic             cond_taken, err_overflow, err_underflow;
  logic [2:0]       stack_depth;

  int checks = 0;
  int errors = 0;

  cpu_microsequencer #(.UPC_W(UPC_W), .STACK_DEPTH(DEPTH),
                       .RESET_ADDR(0), .FETCH_ADDR(0)) dut (
    .clk(clk), .reset(rst_n), .m_cycle(m_cycle), .stall(stall),
    .ubranch(ubranch), .utarget(utarget), .ucond(ucond),
    .flag_z(flag_z), .flag_c(flag_c), .dispatch_addr(dispatch_addr),
    .upc(upc), .cond_taken(cond_taken), .stack_depth(stack_depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: uPC as an integer, return stack as a queue.
  int m_upc;
  int m_stack[$];
  bit m_ovf, m_unf;

  function automatic bit model_cond(input int c, input bit z, input bit cy);
    case (c)
      0: return !z;
      1: return z;
      2: return !cy;
      default: return cy;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_upc = 0;
      m_stack.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (m_cycle && !stall) begin
      automatic int  nxt = (m_upc + 1) % MODV;
      automatic bit  ct  = model_cond(ucond, flag_z, flag_c);
      automatic bit  ret = (ubranch == 5) || (ubranch == 6 && ct);
      if (ret) begin
        if (m_stack.size() > 0) m_upc = m_stack.pop_back();
        else begin
          m_upc = 0;
          m_unf = 1;
        end
      end else begin
        case (ubranch)
          0: m_upc = nxt;
          1: m_upc = utarget;
          2: m_upc = ct ? int'(utarget) : nxt;
          3: m_upc = dispatch_addr;
          4: begin
            if (m_stack.size() < DEPTH) m_stack.push_back(nxt);
            else m_ovf = 1;
            m_upc = utarget;
          end
          6: m_upc = nxt;
          default: m_upc = 0;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("cmp_upc", upc, m_upc);
      check("cmp_depth", stack_depth, m_stack.size());
      check("cmp_ovf", err_overflow, m_ovf);
      check("cmp_unf", err_underflow, m_unf);
      check("cmp_cond", cond_taken, model_cond(ucond, flag_z, flag_c));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input int br, input int tgt);
    m_cycle = 1'b1;
    stall   = 1'b0;
    ubranch = 3'(br);
    utarget = UPC_W'(tgt);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    m_cycle = 0; stall = 0; ubranch = 0; utarget = 0; ucond = 0;
    flag_z = 0; flag_c = 0; dispatch_addr = 0;
    #12 rst_n = 1'b1;
    check("reset_upc", upc, 0);
    check("reset_depth", stack_depth, 0);
    check("reset_errs", {err_overflow, err_underflow}, 0);

    for (int i = 1; i <= 5; i++) begin
      step(0, 0);
      check("next_seq", upc, i);
    end
    step(1, 63);
    check("jump_63", upc, 63);
    step(0, 0);
    check("next_wrap", upc, 0);

    step(1, 10);
    ucond = 2'd1; flag_z = 1'b1;
    step(2, 40);
    check("cjump_taken", upc, 40);
    step(1, 10);
    flag_z = 1'b0;
    step(2, 40);
    check("cjump_not_taken", upc, 11);

    m_cycle = 1'b0;
    for (int u = 0; u < 4; u++)
      for (int f = 0; f < 4; f++) begin
        automatic logic [3:0] tbl [4] = '{4'b0101, 4'b1010, 4'b0011, 4'b1100};
        ucond = 2'(u); flag_z = f[0]; flag_c = f[1];
        #1;
        check("cond_table", cond_taken, tbl[u][f]);
      end
    ucond = 0; flag_z = 0; flag_c = 0;

    step(1, 5);
    step(4, 20);
    check("call1_upc", upc, 20);
    check("call1_depth", stack_depth, 1);
    step(4, 30);
    check("call2_depth", stack_depth, 2);
    step(5, 0);
    check("ret1_upc", upc, 21);
    step(5, 0);
    check("ret2_upc", upc, 6);
    check("ret2_depth", stack_depth, 0);
    check("ret2_errs", {err_overflow, err_underflow}, 0);

    for (int i = 0; i < 5; i++) step(4, 10 + i);
    check("ovf_depth", stack_depth, 4);
    check("ovf_flag", err_overflow, 1);
    check("ovf_upc", upc, 14);
    begin
      automatic int pops [4] = '{13, 12, 11, 7};
      for (int i = 0; i < 4; i++) begin
        step(5, 0);
        check("ovf_pop", upc, pops[i]);
      end
    end
    check("pre_unf_flag", err_underflow, 0);
    step(5, 0);
    check("unf_upc", upc, 0);
    check("unf_flag", err_underflow, 1);
    check("unf_depth", stack_depth, 0);

    step(4, 50);
    ucond = 2'd1; flag_z = 1'b0;
    step(6, 0);
    check("cret_not_taken", upc, 51);
    check("cret_nt_depth", stack_depth, 1);
    flag_z = 1'b1;
    step(6, 0);
    check("cret_taken", upc, 1);
    ucond = 0; flag_z = 0;
    step(1, 33);
    step(7, 0);
    check("fetch", upc, 0);

    step(1, 7);
    dispatch_addr = 6'h2A;
    ubranch = 3'd3; stall = 1'b1; m_cycle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold", upc, 7);
    end
    ubranch = 3'd4;
    tick();
    check("stall_call_depth", stack_depth, 0);
    ubranch = 3'd3; stall = 1'b0;
    tick();
    check("dispatch", upc, 8'h2A);
    m_cycle = 1'b0;
    for (int b = 0; b < 8; b++) begin
      ubranch = 3'(b); utarget = 6'd9;
      tick();
      check("mcycle_low_hold", upc, 8'h2A);
    end

    step(4, 1);
    step(4, 2);
    check("pre_rst_depth", stack_depth, 2);
    check("pre_rst_errs", {err_overflow, err_underflow}, 3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_upc", upc, 0);
    check("async_rst_depth", stack_depth, 0);
    check("async_rst_errs", {err_overflow, err_underflow}, 0);
    #4 rst_n = 1'b1;
    step(0, 0);
    check("post_rst_next", upc, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
